// File: rtl/netdma_write_sequencer_pkg.sv
// Shared types and constants for the netdma write sequencer: descriptor and
// write-master control/response records, flow_control encoding, the status
// record reported per transfer and the sequencer state enumeration.
package netdma_write_sequencer_pkg;

   // flow_control encoding seen by the write master
   localparam logic [1:0] FLOW_IDLE = 2'd0;
   localparam logic [1:0] FLOW_RUN  = 2'd1;
   localparam logic [1:0] FLOW_DONE = 2'd2;

   typedef struct packed {
      logic [15:0] bytecount;
   } control_field_t;

   typedef struct packed {
      logic [31:0]    address;
      control_field_t control_field;
   } descriptor_t;

   typedef struct packed {
      logic [1:0]  flow_control;
      descriptor_t descriptor;
   } master_control_t;

   typedef struct packed {
      logic [15:0] bytecount;
      logic        eop;
      logic        error;
   } master_response_t;

   typedef struct packed {
      logic [15:0] bytecount;
      logic        error;
      logic        aborted;
      logic        timeout;
      logic        empty_desc;
   } wr_status_t;

   typedef enum logic [2:0] {
      IDLE_S   = 3'd0,
      ARM_S    = 3'd1,
      RUN_S    = 3'd2,
      STOP_S   = 3'd3,
      REPORT_S = 3'd4
   } write_seq_state_t;

   // flow_control value the master must see while the sequencer sits in a state
   function automatic logic [1:0] flow_of_state(input write_seq_state_t state);
      logic [1:0] flow;
      case (state)
         RUN_S:   flow = FLOW_RUN;
         STOP_S:  flow = FLOW_DONE;
         default: flow = FLOW_IDLE;
      endcase
      return flow;
   endfunction

   // A descriptor shorter than one full stream word carries no beat to move
   function automatic logic desc_is_empty(input logic [15:0] bytecount,
                                          input int unsigned rem_width);
      return (bytecount >> rem_width) == 16'd0;
   endfunction

endpackage

// File: rtl/netdma_write_sequencer_if.sv
// Bundle of the descriptor, write-master and status handshakes around the
// write sequencer. The sequencer uses the master modport, its environment
// (descriptor FIFO, write master, status consumer) the slave modport.
interface netdma_write_sequencer_if;
   import netdma_write_sequencer_pkg::*;

   logic             desc_valid;
   descriptor_t      desc;
   logic             desc_ready;
   master_control_t  master_control;
   master_response_t master_response;
   logic             status_valid;
   wr_status_t       status;
   logic             status_ready;

   modport master (
      input  desc_valid, desc, master_response, status_ready,
      output desc_ready, master_control, status_valid, status
   );

   modport slave (
      output desc_valid, desc, master_response, status_ready,
      input  desc_ready, master_control, status_valid, status
   );

endinterface

// File: rtl/netdma_write_sequencer_watchdog.sv
// RUN-phase watchdog. Counts cycles while enable_i is high, restarts from
// zero on clear_i and flags expire_o on the TIMEOUT_CYCLES-th enabled cycle.
// The count holds at its last value so expire stays asserted until cleared.
// TIMEOUT_CYCLES == 0 removes the counter and ties expire_o low.
module netdma_watchdog #(
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic enable_i,
   output logic expire_o
);

   generate
      if (TIMEOUT_CYCLES == 0) begin : g_off
         logic unused_s;
         assign unused_s = ^{clk_i, rst_i, clear_i, enable_i};
         assign expire_o = 1'b0;
      end else begin : g_on
         localparam int CW = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);
         localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

         logic [CW-1:0] count_r;
         logic          at_last_s;

         assign at_last_s = (count_r == LAST);
         assign expire_o  = enable_i & at_last_s;

         // cycle counter: restart on clear, advance while enabled, hold at the last value
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               count_r <= '0;
            end else if (clear_i) begin
               count_r <= '0;
            end else if (enable_i && !at_last_s) begin
               count_r <= count_r + CW'(1'b1);
            end else begin
               count_r <= count_r;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/netdma_write_sequencer.sv
// Write sequencer: takes one descriptor at a time from the descriptor FIFO,
// hands it to the netdma write master through flow_control (IDLE -> RUN ->
// optional DONE -> IDLE), collects the transfer result into a status record
// and counts completed descriptors. Handles abort and a RUN-phase watchdog.
module netdma_write_sequencer
   import netdma_write_sequencer_pkg::*;
#(
   parameter int DATA_WIDTH     = 64,
   parameter int TIMEOUT_CYCLES = 0,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       enable_i,
   input  logic                       abort_i,
   netdma_write_sequencer_if.master   bus,
   output logic                       busy_o,
   output logic [CNT_WIDTH-1:0]       done_cnt_o
);

   localparam int BYTES_NUM = DATA_WIDTH / 8;
   localparam int REM_WIDTH = $clog2(BYTES_NUM);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   write_seq_state_t       state_r;
   write_seq_state_t       state_s;
   descriptor_t            desc_r;
   descriptor_t            desc_s;
   wr_status_t             status_r;
   wr_status_t             status_s;
   logic                   first_run_r;
   logic [1:0]             flow_r;
   logic                   status_valid_r;
   logic                   busy_r;
   logic [CNT_WIDTH-1:0]   done_cnt_r;
   logic                   desc_ready_s;
   logic                   done_inc_s;
   logic                   wd_clear_s;
   logic                   wd_enable_s;
   logic                   expire_s;

   // The watchdog restarts in ARM_S so it reads zero on the first RUN cycle
   assign wd_clear_s  = (state_r == ARM_S);
   assign wd_enable_s = (state_r == RUN_S);

   netdma_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clear_i  (wd_clear_s),
      .enable_i (wd_enable_s),
      .expire_o (expire_s)
   );

   // next state, descriptor/status capture and handshake strobes
   always_comb begin
      state_s      = state_r;
      desc_s       = desc_r;
      status_s     = status_r;
      desc_ready_s = 1'b0;
      done_inc_s   = 1'b0;
      case (state_r)
         IDLE_S: begin
            // desc_ready is combinational; it is held low while reset is applied
            if (enable_i && bus.desc_valid && !status_valid_r && !rst_i) begin
               desc_ready_s = 1'b1;
               desc_s       = bus.desc;
               status_s     = '0;
               if (desc_is_empty(bus.desc.control_field.bytecount, REM_WIDTH)) begin
                  status_s.empty_desc = 1'b1;
                  state_s             = REPORT_S;
               end else begin
                  state_s = ARM_S;
               end
            end else begin
               state_s = IDLE_S;
            end
         end
         ARM_S: begin
            // one IDLE cycle so the master sees a clean rising edge of run
            state_s = RUN_S;
         end
         RUN_S: begin
            // the master reloads its counters on the first RUN edge, so its response is ignored then
            if (first_run_r) begin
               state_s = RUN_S;
            end else if (bus.master_response.eop || bus.master_response.error) begin
               status_s.bytecount = bus.master_response.bytecount;
               status_s.error     = bus.master_response.error;
               state_s            = REPORT_S;
            end else if (abort_i) begin
               status_s.aborted = 1'b1;
               state_s          = STOP_S;
            end else if (expire_s) begin
               status_s.timeout = 1'b1;
               state_s          = STOP_S;
            end else begin
               state_s = RUN_S;
            end
         end
         STOP_S: begin
            // partial count as reported by the master while it sees DONE
            status_s.bytecount = bus.master_response.bytecount;
            state_s            = REPORT_S;
         end
         REPORT_S: begin
            if (bus.status_ready) begin
               done_inc_s = 1'b1;
               state_s    = IDLE_S;
            end else begin
               state_s = REPORT_S;
            end
         end
         default: begin
            state_s = IDLE_S;
         end
      endcase
   end

   // state, captured records and registered outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r        <= IDLE_S;
         desc_r         <= '0;
         status_r       <= '0;
         first_run_r    <= 1'b0;
         flow_r         <= FLOW_IDLE;
         status_valid_r <= 1'b0;
         busy_r         <= 1'b0;
         done_cnt_r     <= '0;
      end else begin
         state_r        <= state_s;
         desc_r         <= desc_s;
         status_r       <= status_s;
         first_run_r    <= (state_r == ARM_S);
         flow_r         <= flow_of_state(state_s);
         status_valid_r <= (state_s == REPORT_S);
         busy_r         <= (state_s != IDLE_S);
         if (done_inc_s) begin
            done_cnt_r <= done_cnt_r + CNT_ONE;
         end else begin
            done_cnt_r <= done_cnt_r;
         end
      end
   end

   assign bus.desc_ready     = desc_ready_s;
   assign bus.master_control = {flow_r, desc_r};
   assign bus.status_valid   = status_valid_r;
   assign bus.status         = status_r;
   assign busy_o             = busy_r;
   assign done_cnt_o         = done_cnt_r;

endmodule
